// File: rtl/vector_operand_fetch_if.sv
// Bus bundle for the vector operand fetch stage: issue handshake, register
// file read port, write-back commit and the operand bundle towards execute.
interface vector_operand_fetch_if #(
    parameter int VLEN           = 128,
    parameter int REG_ADDR_WIDTH = 5
);
    // issue side
    logic                      issue_valid;
    logic                      issue_ready;
    logic [REG_ADDR_WIDTH-1:0] issue_vs1_address;
    logic [REG_ADDR_WIDTH-1:0] issue_vs2_address;
    logic [REG_ADDR_WIDTH-1:0] issue_vd_address;
    logic                      issue_uses_vs1;
    logic                      issue_uses_vs2;
    logic                      issue_masked;
    logic                      issue_writes_vd;
    // register file read port
    logic                      vrf_read_enable;
    logic [REG_ADDR_WIDTH-1:0] vrf_read_address;
    logic [VLEN-1:0]           vrf_read_data;
    // write-back commit
    logic                      commit_valid;
    logic [REG_ADDR_WIDTH-1:0] commit_address;
    // operand bundle to execute
    logic                      operand_valid;
    logic                      operand_ready;
    logic [VLEN-1:0]           vs1;
    logic [VLEN-1:0]           vs2;
    logic [VLEN-1:0]           vd_old;
    logic [VLEN-1:0]           v0;
    logic [REG_ADDR_WIDTH-1:0] operand_vd_address;
    logic                      operand_writes_vd;

    // the fetch stage itself
    modport slave (
        input  issue_valid, issue_vs1_address, issue_vs2_address, issue_vd_address,
               issue_uses_vs1, issue_uses_vs2, issue_masked, issue_writes_vd,
               vrf_read_data, commit_valid, commit_address, operand_ready,
        output issue_ready, vrf_read_enable, vrf_read_address, operand_valid,
               vs1, vs2, vd_old, v0, operand_vd_address, operand_writes_vd
    );

    // the surrounding pipeline (issue, register file, write-back, execute)
    modport master (
        output issue_valid, issue_vs1_address, issue_vs2_address, issue_vd_address,
               issue_uses_vs1, issue_uses_vs2, issue_masked, issue_writes_vd,
               vrf_read_data, commit_valid, commit_address, operand_ready,
        input  issue_ready, vrf_read_enable, vrf_read_address, operand_valid,
               vs1, vs2, vd_old, v0, operand_vd_address, operand_writes_vd
    );
endinterface

// File: rtl/vector_operand_fetch.sv
// Vector operand fetch: waits out read-after-write hazards against a pending
// write scoreboard, reads vs1/vs2/vd_old/v0 through the single synchronous
// register file port and hands one operand bundle per instruction to execute.
module vector_operand_fetch #(
    parameter int VLEN           = 128,
    parameter int REG_ADDR_WIDTH = 5
) (
    input logic             clock,
    input logic             reset,
    vector_operand_fetch_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, HAZARD, READ, DRAIN, VALID} state_t;
    typedef enum logic [1:0] {OP_VS1, OP_VS2, OP_VD, OP_V0} op_t;

    state_t state, state_next;
    op_t    read_index, read_index_next, capture_index, first_index, following_index;
    logic   capture_pending, last_read, hazard, accept, retire;

    logic [REG_ADDR_WIDTH-1:0] vs1_address, vs2_address, vd_address, current_address;
    logic                      uses_vs1, uses_vs2, masked, writes_vd;
    logic [NUM_REGS-1:0]       scoreboard, scoreboard_next;
    logic [VLEN-1:0]           vs1_q, vs2_q, vd_old_q, v0_q;

    logic                      issue_ready_c, read_enable_c, operand_valid_c;
    logic [REG_ADDR_WIDTH-1:0] read_address_c;

    // Hazard detection and read sequencing over the latched instruction.
    always_comb begin
        hazard = (uses_vs1 && scoreboard[vs1_address]) ||
                 (uses_vs2 && scoreboard[vs2_address]) ||
                 scoreboard[vd_address] ||
                 (masked && scoreboard[0]);
        first_index = uses_vs1 ? OP_VS1 : (uses_vs2 ? OP_VS2 : OP_VD);
        following_index = OP_VD;
        last_read = 1'b0;
        current_address = '0;
        case (read_index)
            OP_VS1: begin
                following_index = uses_vs2 ? OP_VS2 : OP_VD;
                current_address = vs1_address;
            end
            OP_VS2: begin
                following_index = OP_VD;
                current_address = vs2_address;
            end
            OP_VD: begin
                following_index = OP_V0;
                last_read = !masked;
                current_address = vd_address;
            end
            OP_V0: begin
                following_index = OP_V0;
                last_read = 1'b1;
                current_address = '0;
            end
            default: ;
        endcase
    end

    // FSM next state and outputs.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        read_index_next = read_index;
        issue_ready_c   = 1'b0;
        read_enable_c   = 1'b0;
        read_address_c  = '0;
        operand_valid_c = 1'b0;
        accept          = 1'b0;
        retire          = 1'b0;
        case (state)
            IDLE: begin
                issue_ready_c = 1'b1;
                if (bus.issue_valid) begin
                    accept     = 1'b1;
                    state_next = HAZARD;
                end
            end
            HAZARD: begin
                if (!hazard) begin
                    state_next      = READ;
                    read_index_next = first_index;
                end
            end
            READ: begin
                read_enable_c  = 1'b1;
                read_address_c = current_address;
                if (last_read) state_next = DRAIN;
                else           read_index_next = following_index;
            end
            DRAIN: state_next = VALID;
            VALID: begin
                operand_valid_c = 1'b1;
                if (bus.operand_ready) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Scoreboard update: commit clears, a retiring writer sets; set wins.
    always_comb begin
        scoreboard_next = scoreboard;
        if (bus.commit_valid) scoreboard_next[bus.commit_address] = 1'b0;
        if (retire && writes_vd) scoreboard_next[vd_address] = 1'b1;
    end

    // State, read index and the one-cycle-delayed capture tag.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            read_index      <= OP_VS1;
            capture_index   <= OP_VS1;
            capture_pending <= 1'b0;
        end else begin
            state           <= state_next;
            read_index      <= read_index_next;
            capture_index   <= read_index;
            capture_pending <= read_enable_c;
        end
    end

    // Latch the instruction fields on the issue handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vs1_address <= '0;
            vs2_address <= '0;
            vd_address  <= '0;
            uses_vs1    <= 1'b0;
            uses_vs2    <= 1'b0;
            masked      <= 1'b0;
            writes_vd   <= 1'b0;
        end else if (accept) begin
            vs1_address <= bus.issue_vs1_address;
            vs2_address <= bus.issue_vs2_address;
            vd_address  <= bus.issue_vd_address;
            uses_vs1    <= bus.issue_uses_vs1;
            uses_vs2    <= bus.issue_uses_vs2;
            masked      <= bus.issue_masked;
            writes_vd   <= bus.issue_writes_vd;
        end
    end

    // Operand slots: cleared on issue, filled one cycle after each read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_old_q <= '0;
            v0_q     <= '0;
        end else if (accept) begin
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_old_q <= '0;
            v0_q     <= '0;
        end else if (capture_pending) begin
            case (capture_index)
                OP_VS1:  vs1_q    <= bus.vrf_read_data;
                OP_VS2:  vs2_q    <= bus.vrf_read_data;
                OP_VD:   vd_old_q <= bus.vrf_read_data;
                OP_V0:   v0_q     <= bus.vrf_read_data;
                default: ;
            endcase
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) scoreboard <= '0;
        else       scoreboard <= scoreboard_next;
    end

    assign bus.issue_ready        = issue_ready_c;
    assign bus.vrf_read_enable    = read_enable_c;
    assign bus.vrf_read_address   = read_address_c;
    assign bus.operand_valid      = operand_valid_c;
    assign bus.vs1                = vs1_q;
    assign bus.vs2                = vs2_q;
    assign bus.vd_old             = vd_old_q;
    assign bus.v0                 = v0_q;
    assign bus.operand_vd_address = vd_address;
    assign bus.operand_writes_vd  = writes_vd;
endmodule

// File: tb/tb_vector_operand_fetch.sv
// Directed bench for vector_operand_fetch: a one-cycle-latency register file
// model (reg n holds n unless a test overrides it), issue/commit/execute
// drivers and per-scenario tasks with hand-computed expectations.
module tb_vector_operand_fetch;
    localparam int VLEN = 128;
    localparam int AW   = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   hs_cyc = 0;
    int   log_addr[$];
    int   log_cyc[$];
    logic [VLEN-1:0] mem [32];

    vector_operand_fetch_if #(.VLEN(VLEN), .REG_ADDR_WIDTH(AW)) bus ();

    vector_operand_fetch #(.VLEN(VLEN), .REG_ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // register file model: data for the address of cycle k appears in k+1
    always @(posedge clock) begin
        if (bus.vrf_read_enable) bus.vrf_read_data <= mem[bus.vrf_read_address];
    end

    // log every read request with the cycle it was made in
    always @(negedge clock) begin
        if (!reset && bus.vrf_read_enable === 1'b1) begin
            log_addr.push_back(int'(bus.vrf_read_address));
            log_cyc.push_back(cyc);
        end
    end

    task automatic issue(input int a1, input int a2, input int ad,
                         input bit u1, input bit u2, input bit m, input bit w);
        @(negedge clock);
        bus.issue_vs1_address = a1[AW-1:0];
        bus.issue_vs2_address = a2[AW-1:0];
        bus.issue_vd_address  = ad[AW-1:0];
        bus.issue_uses_vs1    = u1;
        bus.issue_uses_vs2    = u2;
        bus.issue_masked      = m;
        bus.issue_writes_vd   = w;
        bus.issue_valid       = 1'b1;
        log_addr.delete();
        log_cyc.delete();
        hs_cyc = cyc;
        tests_run++;
        if (bus.issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL issue_ready_at_issue: got %b expected 1", bus.issue_ready);
        end
        @(posedge clock);
        #1 bus.issue_valid = 1'b0;
    endtask

    task automatic wait_valid(output int rel);
        int k = 0;
        rel = -1;
        while (k < 40) begin
            @(negedge clock);
            if (bus.operand_valid === 1'b1) begin
                rel = cyc - hs_cyc;
                break;
            end
            k++;
        end
    endtask

    task automatic accept_bundle();
        bus.operand_ready = 1'b1;
        @(posedge clock);
        #1 bus.operand_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus.issue_ready !== 1'b1 || bus.vrf_read_enable !== 1'b0 || bus.operand_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got ready=%b ren=%b valid=%b expected 1 0 0",
                     bus.issue_ready, bus.vrf_read_enable, bus.operand_valid);
        end
        tests_run++;
        if (bus.vrf_read_address !== '0 || bus.operand_vd_address !== '0 || bus.operand_writes_vd !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_addr: got raddr=%0d vd=%0d wvd=%b expected 0 0 0",
                     bus.vrf_read_address, bus.operand_vd_address, bus.operand_writes_vd);
        end
        tests_run++;
        if ((bus.vs1 | bus.vs2 | bus.vd_old | bus.v0) !== '0) begin
            tests_failed++;
            $display("FAIL reset_bundle: got %0h %0h %0h %0h expected all 0",
                     bus.vs1, bus.vs2, bus.vd_old, bus.v0);
        end
    endtask

    task automatic test_basic();
        int rel;
        int exp_a[3] = '{3, 4, 5};
        issue(3, 4, 5, 1, 1, 0, 0);
        wait_valid(rel);
        tests_run++;
        if (rel !== 6) begin
            tests_failed++;
            $display("FAIL basic_latency: got cycle %0d expected 6", rel);
        end
        tests_run++;
        if (bus.vs1 !== 128'd3 || bus.vs2 !== 128'd4 || bus.vd_old !== 128'd5 || bus.v0 !== 128'd0) begin
            tests_failed++;
            $display("FAIL basic_bundle: got %0h %0h %0h %0h expected 3 4 5 0",
                     bus.vs1, bus.vs2, bus.vd_old, bus.v0);
        end
        tests_run++;
        if (log_addr.size() !== 3) begin
            tests_failed++;
            $display("FAIL basic_read_count: got %0d expected 3", log_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (log_addr[i] !== exp_a[i] || log_cyc[i] - hs_cyc !== 2 + i) begin
                    tests_failed++;
                    $display("FAIL basic_read%0d: got addr %0d cycle %0d expected addr %0d cycle %0d",
                             i, log_addr[i], log_cyc[i] - hs_cyc, exp_a[i], 2 + i);
                end
            end
        end
        tests_run++;
        if (bus.operand_vd_address !== 5'd5 || bus.operand_writes_vd !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_vd_fields: got %0d %b expected 5 0",
                     bus.operand_vd_address, bus.operand_writes_vd);
        end
        accept_bundle();
        @(negedge clock);
        tests_run++;
        if (bus.operand_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_retire: got valid=%b ready=%b expected 0 1",
                     bus.operand_valid, bus.issue_ready);
        end
    endtask

    task automatic test_masked();
        int rel;
        int exp_a[3] = '{7, 2, 0};
        // vs1 address offered but unused: must not be read, slot stays 0
        issue(11, 7, 2, 0, 1, 1, 0);
        wait_valid(rel);
        tests_run++;
        if (rel !== 6) begin
            tests_failed++;
            $display("FAIL masked_latency: got cycle %0d expected 6", rel);
        end
        tests_run++;
        if (bus.vs1 !== 128'd0 || bus.vs2 !== 128'd7 || bus.vd_old !== 128'd2 || bus.v0 !== 128'd0) begin
            tests_failed++;
            $display("FAIL masked_bundle: got %0h %0h %0h %0h expected 0 7 2 0",
                     bus.vs1, bus.vs2, bus.vd_old, bus.v0);
        end
        tests_run++;
        if (log_addr.size() !== 3) begin
            tests_failed++;
            $display("FAIL masked_read_count: got %0d expected 3", log_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (log_addr[i] !== exp_a[i]) begin
                    tests_failed++;
                    $display("FAIL masked_read%0d: got %0d expected %0d", i, log_addr[i], exp_a[i]);
                end
            end
        end
        accept_bundle();

        // vd = 0 with mask: register 0 is read twice
        mem[0] = 128'hABCD;
        issue(0, 0, 0, 0, 0, 1, 0);
        wait_valid(rel);
        tests_run++;
        if (rel !== 5 || log_addr.size() !== 2) begin
            tests_failed++;
            $display("FAIL v0_twice_timing: got cycle %0d reads %0d expected 5 2", rel, log_addr.size());
        end
        tests_run++;
        if (bus.vd_old !== 128'hABCD || bus.v0 !== 128'hABCD || bus.vs1 !== 128'd0 || bus.vs2 !== 128'd0) begin
            tests_failed++;
            $display("FAIL v0_twice_bundle: got %0h %0h %0h %0h expected 0 0 abcd abcd",
                     bus.vs1, bus.vs2, bus.vd_old, bus.v0);
        end
        accept_bundle();
        mem[0] = 128'd0;
    endtask

    task automatic test_hazard();
        int rel;
        int t;
        issue(1, 2, 9, 1, 1, 0, 1);
        wait_valid(rel);
        accept_bundle();
        issue(9, 0, 10, 1, 0, 0, 0);
        repeat (4) @(negedge clock);
        tests_run++;
        if (log_addr.size() !== 0 || bus.issue_ready !== 1'b0 || bus.operand_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL hazard_stall: got reads=%0d ready=%b valid=%b expected 0 0 0",
                     log_addr.size(), bus.issue_ready, bus.operand_valid);
        end
        bus.commit_valid   = 1'b1;
        bus.commit_address = 5'd9;
        t = cyc;
        @(posedge clock);
        #1 bus.commit_valid = 1'b0;
        wait_valid(rel);
        tests_run++;
        if (log_addr.size() < 1 || log_addr[0] !== 9 || log_cyc[0] !== t + 2) begin
            tests_failed++;
            $display("FAIL hazard_release: got first read addr %0d at t+%0d expected 9 at t+2",
                     (log_addr.size() > 0) ? log_addr[0] : -1,
                     (log_cyc.size() > 0) ? log_cyc[0] - t : -1);
        end
        tests_run++;
        if (bus.vs1 !== 128'd9 || bus.vd_old !== 128'd10) begin
            tests_failed++;
            $display("FAIL hazard_bundle: got vs1=%0h vd_old=%0h expected 9 a", bus.vs1, bus.vd_old);
        end
        accept_bundle();
    endtask

    task automatic test_backpressure();
        int rel;
        logic [VLEN-1:0] snap;
        int stable_errs = 0;
        // same register for every operand, masked: four reads, no merging
        issue(8, 8, 8, 1, 1, 1, 0);
        wait_valid(rel);
        tests_run++;
        if (rel !== 7 || log_addr.size() !== 4) begin
            tests_failed++;
            $display("FAIL n4_timing: got cycle %0d reads %0d expected 7 4", rel, log_addr.size());
        end
        snap = bus.vs1 ^ bus.vs2 ^ bus.vd_old;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (bus.operand_valid !== 1'b1 || bus.issue_ready !== 1'b0 ||
                bus.vs1 !== 128'd8 || bus.vs2 !== 128'd8 || bus.vd_old !== 128'd8 || bus.v0 !== 128'd0)
                stable_errs++;
        end
        tests_run++;
        if (stable_errs !== 0 || snap !== 128'd8) begin
            tests_failed++;
            $display("FAIL hold_stable: got %0d unstable cycles expected 0", stable_errs);
        end
        accept_bundle();
        @(negedge clock);
        tests_run++;
        if (bus.operand_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_release: got valid=%b ready=%b expected 0 1",
                     bus.operand_valid, bus.issue_ready);
        end
    endtask

    task automatic test_set_clear();
        int rel;
        issue(1, 1, 6, 0, 0, 0, 1);
        wait_valid(rel);
        bus.commit_valid   = 1'b1;
        bus.commit_address = 5'd6;
        bus.operand_ready  = 1'b1;
        @(posedge clock);
        #1;
        bus.commit_valid  = 1'b0;
        bus.operand_ready = 1'b0;
        issue(0, 6, 11, 0, 1, 0, 0);
        repeat (6) @(negedge clock);
        tests_run++;
        if (log_addr.size() !== 0 || bus.operand_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL set_wins: got reads=%0d valid=%b expected 0 0",
                     log_addr.size(), bus.operand_valid);
        end
        bus.commit_valid   = 1'b1;
        bus.commit_address = 5'd6;
        @(posedge clock);
        #1 bus.commit_valid = 1'b0;
        wait_valid(rel);
        tests_run++;
        if (rel < 0 || bus.vs2 !== 128'd6 || bus.vd_old !== 128'd11) begin
            tests_failed++;
            $display("FAIL set_wins_release: got cycle %0d vs2=%0h vd_old=%0h expected valid 6 b",
                     rel, bus.vs2, bus.vd_old);
        end
        accept_bundle();
    endtask

    task automatic test_reset_mid();
        int rel;
        int k = 0;
        issue(1, 2, 12, 1, 1, 0, 1);
        wait_valid(rel);
        accept_bundle();
        issue(1, 2, 3, 1, 1, 0, 0);
        while (bus.vrf_read_enable !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        tests_run++;
        if (bus.vrf_read_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reach_read: got ren=%b expected 1", bus.vrf_read_enable);
        end
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (bus.issue_ready !== 1'b1 || bus.vrf_read_enable !== 1'b0 || bus.operand_valid !== 1'b0 ||
            (bus.vs1 | bus.vs2 | bus.vd_old | bus.v0) !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_state: got ready=%b ren=%b valid=%b expected 1 0 0 and zero bundle",
                     bus.issue_ready, bus.vrf_read_enable, bus.operand_valid);
        end
        reset = 1'b0;
        // register 12 was pending before reset; a cleared scoreboard must not stall
        issue(12, 0, 13, 1, 0, 0, 0);
        wait_valid(rel);
        tests_run++;
        if (rel !== 5 || bus.vs1 !== 128'd12 || bus.vd_old !== 128'd13) begin
            tests_failed++;
            $display("FAIL mid_scoreboard_clear: got cycle %0d vs1=%0h vd_old=%0h expected 5 c d",
                     rel, bus.vs1, bus.vd_old);
        end
        accept_bundle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = VLEN'(i);
        bus.issue_valid       = 1'b0;
        bus.issue_vs1_address = '0;
        bus.issue_vs2_address = '0;
        bus.issue_vd_address  = '0;
        bus.issue_uses_vs1    = 1'b0;
        bus.issue_uses_vs2    = 1'b0;
        bus.issue_masked      = 1'b0;
        bus.issue_writes_vd   = 1'b0;
        bus.commit_valid      = 1'b0;
        bus.commit_address    = '0;
        bus.operand_ready     = 1'b0;
        bus.vrf_read_data     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_masked();
        test_hazard();
        test_backpressure();
        test_set_clear();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // absolute time bound in case a wait is never satisfied
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vector_operand_fetch.md
Name: vector_operand_fetch

Overview:
- Read-side counterpart of the write-back stage: sequences operand reads (vs1, vs2, vd_old, v0) from the vector register file's single synchronous read port.
- Tracks registers with pending writes in a scoreboard and stalls on read-after-write hazards.
- Sits between issue and execute. Hands execute one complete operand bundle per instruction over a valid/ready handshake.

Parameters:
- VLEN, 128, vector register width in bits (one data packet).
- REG_ADDR_WIDTH, 5, register address width; NUM_REGS = 2**REG_ADDR_WIDTH.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  instruction offered.
- issue_ready  out  1  block can accept an instruction.
- issue_vs1_address  in  REG_ADDR_WIDTH  source 1 register.
- issue_vs2_address  in  REG_ADDR_WIDTH  source 2 register.
- issue_vd_address  in  REG_ADDR_WIDTH  destination register; always read as vd_old.
- issue_uses_vs1  in  1  vs1 needed.
- issue_uses_vs2  in  1  vs2 needed.
- issue_masked  in  1  v0 (address 0) needed as mask.
- issue_writes_vd  in  1  instruction will write vd.
- vrf_read_enable  out  1  register file read request.
- vrf_read_address  out  REG_ADDR_WIDTH  read address.
- vrf_read_data  in  VLEN  data for the address presented on the previous cycle.
- commit_valid  in  1  write-back wrote a register this cycle.
- commit_address  in  REG_ADDR_WIDTH  register written.
- operand_valid  out  1  bundle available.
- operand_ready  in  1  execute accepts the bundle.
- vs1, vs2, vd_old, v0  out  VLEN each  operand bundle; unread operands are 0.
- operand_vd_address  out  REG_ADDR_WIDTH  latched destination.
- operand_writes_vd  out  1  latched write flag.

Behaviour:
- Reset: state IDLE; scoreboard cleared.
  - Outputs: issue_ready=1, vrf_read_enable=0, vrf_read_address=0, operand_valid=0, all operand and data outputs 0.
  - Reset asserted mid-operation aborts the instruction immediately; nothing partial is presented.
- Read order: vs1 (if uses_vs1), vs2 (if uses_vs2), vd (always), v0 (if masked). N = number of needed reads, 1..4.
- Register file read latency is 1 cycle: data for the address driven in cycle k is captured at the end of cycle k+1 into the slot selected by a registered copy of the read index.
- FSM:
  - IDLE: issue_ready=1. On issue_valid&&issue_ready, latch all issue fields, zero the operand registers, go to HAZARD.
  - HAZARD: issue_ready=0. Stall while any needed register has its scoreboard bit set.
    - Needed registers: vs1 if used, vs2 if used, vd, register 0 if masked.
    - When all are clear, go to READ with the index at the first needed operand.
  - READ: vrf_read_enable=1, address = current operand. Advance to the next needed operand each cycle, skipping unneeded ones. After the last one, go to DRAIN. Occupies N cycles.
  - DRAIN: vrf_read_enable=0; capture the last read; go to VALID.
  - VALID: operand_valid=1; all bundle outputs stable until operand_ready. On handshake:
    - if operand_writes_vd, set scoreboard[vd];
    - go to IDLE, with operand_valid=0 next cycle.
- Latency: handshake at edge E0 → HAZARD in cycle 1 → operand_valid high from cycle N+3 when there is no hazard. Each stall cycle adds 1.
- Throughput: one instruction in flight. issue_ready is high only in IDLE.
- Scoreboard:
  - commit_valid clears scoreboard[commit_address] at the clock edge.
  - The hazard check reads the registered scoreboard, so a same-cycle commit releases the stall on the following cycle.
  - A set and clear of the same register in the same cycle results in set (new pending write wins).
  - A commit to a register that is not busy has no effect.
- The same register used for several operands is read once per use, in order. No merging.
- vd equal to 0 with masked=1 gives two reads of register 0; both reads are performed.

Test Plan:
- Reset released, issue vs1=3, vs2=4, vd=5, unmasked, register file holding reg n = n → operand_valid at cycle 6. Required bundle: vs1=3, vs2=4, vd_old=5, v0=0. Read addresses 3,4,5 on consecutive cycles.
- Masked, vs2 only, vs2=7, vd=2 → N=3. Reads 7,2,0. Bundle: vs1=0, vs2=7, vd_old=2, v0=0x0.
- Instruction A writes vd=9 and is accepted by execute. Instruction B reads vs1=9 → B stalls in HAZARD. Commit 9 at cycle t → B's first read of 9 occurs in cycle t+2.
- Hold operand_ready=0 for 5 cycles in VALID → operand_valid and the bundle stay stable, issue_ready=0. Then ready=1 → IDLE next cycle.
- Commit of register 6 in the same cycle as the output handshake setting register 6 → scoreboard[6]=1 afterwards. A subsequent read of 6 stalls.
- Assert reset during READ → next cycle: IDLE, vrf_read_enable=0, operand_valid=0, scoreboard all 0.
